// File: rtl/wash_cycle_sequencer_pkg.sv
// Shared types for the wash cycle sequencer.
// Phase encoding, motor codes and phase ordering helpers.
package wash_cycle_sequencer_pkg;

  typedef enum logic [3:0] {
    PH_IDLE        = 4'd0,
    PH_FILL        = 4'd1,
    PH_WASH        = 4'd2,
    PH_DRAIN1      = 4'd3,
    PH_RINSE       = 4'd4,
    PH_DRAIN2      = 4'd5,
    PH_SPIN        = 4'd6,
    PH_DONE        = 4'd7,
    PH_ABORT_DRAIN = 4'd8
  } phase_e;

  localparam logic [1:0] MOTOR_OFF     = 2'b00;
  localparam logic [1:0] MOTOR_AGITATE = 2'b01;
  localparam logic [1:0] MOTOR_SPIN    = 2'b10;

  // True for the timed phases that pause and abort act on.
  function automatic logic is_active(phase_e ph);
    return (ph >= PH_FILL) && (ph <= PH_SPIN);
  endfunction

  // Phase that follows cur, skipping zero-length wash/rinse/spin.
  function automatic phase_e next_phase(
    phase_e cur,
    logic   wash_nz,
    logic   rinse_nz,
    logic   spin_nz
  );
    phase_e nxt;
    nxt = PH_DONE;
    unique case (cur)
      PH_FILL:   nxt = wash_nz  ? PH_WASH  : PH_DRAIN1;
      PH_WASH:   nxt = PH_DRAIN1;
      PH_DRAIN1: nxt = rinse_nz ? PH_RINSE : PH_DRAIN2;
      PH_RINSE:  nxt = PH_DRAIN2;
      PH_DRAIN2: nxt = spin_nz  ? PH_SPIN  : PH_DONE;
      default:   nxt = PH_DONE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/wash_cycle_sequencer_phase_timer.sv
// Phase timer: tick prescaler plus time-unit down-counter.
// expire flags the tick that consumes the last unit.
module wash_cycle_sequencer_phase_timer #(
  parameter int TICK_DIV = 10,
  parameter int W        = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         hold,
  output logic [W-1:0] remaining,
  output logic         expire
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [W-1:0]  rem_q, rem_d;
  logic          tick;

  // Prescaler/counter next state; load wins over hold.
  always_comb begin
    tick    = !hold && (presc_q == LAST);
    expire  = tick && (rem_q == W'(1));
    presc_d = presc_q;
    rem_d   = rem_q;
    if (load) begin
      presc_d = '0;
      rem_d   = load_val;
    end else if (!hold) begin
      if (tick) begin
        presc_d = '0;
        rem_d   = rem_q - 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      rem_q   <= '0;
    end else begin
      presc_q <= presc_d;
      rem_q   <= rem_d;
    end
  end

  assign remaining = rem_q;

endmodule

// File: rtl/wash_cycle_sequencer.sv
// Washing machine cycle sequencer: fill, wash, drain, rinse,
// drain, spin, with pause, abort drain and registered actuators.
module wash_cycle_sequencer
  import wash_cycle_sequencer_pkg::*;
#(
  parameter int TICK_DIV    = 10,
  parameter int DRAIN_UNITS = 2,
  parameter int W           = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         pause,
  input  logic         abort,
  input  logic [W-1:0] wash_in,
  input  logic [W-1:0] rinse_in,
  input  logic [W-1:0] spin_in,
  input  logic [W-1:0] cloth_in,
  output logic [3:0]   phase,
  output logic [W-1:0] remaining,
  output logic         valve_in,
  output logic         drain_pump,
  output logic [1:0]   motor,
  output logic         door_lock,
  output logic         busy,
  output logic         done
);

  localparam logic [W-1:0] DRAIN_U = W'(DRAIN_UNITS);

  phase_e       phase_q, phase_d;
  phase_e       nxt_phase;
  logic [W-1:0] nxt_units;
  logic [W-1:0] wash_q, wash_d;
  logic [W-1:0] rinse_q, rinse_d;
  logic [W-1:0] spin_q, spin_d;
  logic         valve_q, valve_d;
  logic         pump_q, pump_d;
  logic [1:0]   motor_q, motor_d;
  logic         lock_q, lock_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         load;
  logic [W-1:0] load_val;
  logic         hold;
  logic         expire;

  wash_cycle_sequencer_phase_timer #(
    .TICK_DIV (TICK_DIV),
    .W        (W)
  ) u_phase_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_val  (load_val),
    .hold      (hold),
    .remaining (remaining),
    .expire    (expire)
  );

  // Successor of the current timed phase and its duration.
  always_comb begin
    nxt_phase = next_phase(phase_q, wash_q != '0,
                           rinse_q != '0, spin_q != '0);
    nxt_units = '0;
    unique case (nxt_phase)
      PH_WASH:   nxt_units = wash_q;
      PH_RINSE:  nxt_units = rinse_q;
      PH_SPIN:   nxt_units = spin_q;
      PH_DRAIN1: nxt_units = DRAIN_U;
      PH_DRAIN2: nxt_units = DRAIN_U;
      default:   nxt_units = '0;
    endcase
  end

  // Phase FSM: start, abort, expiry; timer load and hold.
  always_comb begin
    phase_d  = phase_q;
    wash_d   = wash_q;
    rinse_d  = rinse_q;
    spin_d   = spin_q;
    load     = 1'b0;
    load_val = '0;
    hold     = !(is_active(phase_q) ||
                 phase_q == PH_ABORT_DRAIN) ||
               (pause && is_active(phase_q));
    unique case (phase_q)
      PH_IDLE: begin
        if (start && cloth_in != '0) begin
          phase_d  = PH_FILL;
          wash_d   = wash_in;
          rinse_d  = rinse_in;
          spin_d   = spin_in;
          load     = 1'b1;
          load_val = cloth_in;
        end
      end
      PH_DONE: phase_d = PH_IDLE;
      PH_ABORT_DRAIN: begin
        if (expire) phase_d = PH_IDLE;
      end
      default: begin
        if (abort) begin
          phase_d  = PH_ABORT_DRAIN;
          load     = 1'b1;
          load_val = DRAIN_U;
        end else if (expire) begin
          phase_d  = nxt_phase;
          load     = 1'b1;
          load_val = nxt_units;
        end
      end
    endcase
  end

  // Actuator decode for the upcoming phase, gated by pause.
  always_comb begin
    valve_d = 1'b0;
    pump_d  = 1'b0;
    motor_d = MOTOR_OFF;
    unique case (phase_d)
      PH_FILL:  valve_d = 1'b1;
      PH_WASH:  motor_d = MOTOR_AGITATE;
      PH_RINSE: begin
        valve_d = 1'b1;
        motor_d = MOTOR_AGITATE;
      end
      PH_SPIN: begin
        motor_d = MOTOR_SPIN;
        pump_d  = 1'b1;
      end
      PH_DRAIN1, PH_DRAIN2, PH_ABORT_DRAIN:
        pump_d = 1'b1;
      default: ;
    endcase
    if (pause && is_active(phase_d)) begin
      valve_d = 1'b0;
      pump_d  = 1'b0;
      motor_d = MOTOR_OFF;
    end
    lock_d = phase_d != PH_IDLE;
    busy_d = phase_d != PH_IDLE;
    done_d = phase_d == PH_DONE;
  end

  // State, latched settings and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_IDLE;
      wash_q  <= '0;
      rinse_q <= '0;
      spin_q  <= '0;
      valve_q <= 1'b0;
      pump_q  <= 1'b0;
      motor_q <= MOTOR_OFF;
      lock_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      wash_q  <= wash_d;
      rinse_q <= rinse_d;
      spin_q  <= spin_d;
      valve_q <= valve_d;
      pump_q  <= pump_d;
      motor_q <= motor_d;
      lock_q  <= lock_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign phase      = phase_q;
  assign valve_in   = valve_q;
  assign drain_pump = pump_q;
  assign motor      = motor_q;
  assign door_lock  = lock_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Testbench for wash_cycle_sequencer.
// Expected traces come from a phase-list model of the cycle.
module tb_wash_cycle_sequencer;

  localparam int TD = 2;
  localparam int DR = 2;
  localparam int W  = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         pause = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] wash_in = '0;
  logic [W-1:0] rinse_in = '0;
  logic [W-1:0] spin_in = '0;
  logic [W-1:0] cloth_in = '0;
  logic [3:0]   phase;
  logic [W-1:0] remaining;
  logic         valve_in;
  logic         drain_pump;
  logic [1:0]   motor;
  logic         door_lock;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  wash_cycle_sequencer #(
    .TICK_DIV    (TD),
    .DRAIN_UNITS (DR),
    .W           (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pause      (pause),
    .abort      (abort),
    .wash_in    (wash_in),
    .rinse_in   (rinse_in),
    .spin_in    (spin_in),
    .cloth_in   (cloth_in),
    .phase      (phase),
    .remaining  (remaining),
    .valve_in   (valve_in),
    .drain_pump (drain_pump),
    .motor      (motor),
    .door_lock  (door_lock),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   ph;
    logic [W-1:0] rem;
    logic         v;
    logic         p;
    logic [1:0]   m;
    logic         lk;
    logic         b;
    logic         d;
  } obs_t;

  obs_t exp_q[$];
  int   c_busy, c_done, c_wash, c_spin, c_done_idx;

  // Outputs expected for a phase, straight from the actuator table.
  function automatic obs_t mk(int ph, int rem);
    obs_t o;
    o.ph  = 4'(ph);
    o.rem = W'(rem);
    o.v   = (ph == 1 || ph == 4);
    o.p   = (ph == 3 || ph == 5 || ph == 6 || ph == 8);
    o.m   = (ph == 2 || ph == 4) ? 2'd1 :
            (ph == 6) ? 2'd2 : 2'd0;
    o.lk  = (ph != 0);
    o.b   = (ph != 0);
    o.d   = (ph == 7);
    return o;
  endfunction

  function automatic obs_t masked(obs_t o);
    obs_t r;
    r = o;
    if (o.ph >= 1 && o.ph <= 6) begin
      r.v = 1'b0;
      r.p = 1'b0;
      r.m = 2'd0;
    end
    return r;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.ph  = phase;
    o.rem = remaining;
    o.v   = valve_in;
    o.p   = drain_pump;
    o.m   = motor;
    o.lk  = door_lock;
    o.b   = busy;
    o.d   = done;
    return o;
  endfunction

  // Per-cycle expected trace: phases back to back, each N*TD
  // cycles, then pause stretches and abort truncation.
  task automatic build_exp(input int cl, input int wa,
                           input int ri, input int sp,
                           input int ps, input int pl,
                           input int ab);
    int   u[7];
    obs_t h;
    u = '{0, cl, wa, DR, ri, DR, sp};
    exp_q.delete();
    for (int ph = 1; ph <= 6; ph++)
      for (int c = 0; c < u[ph] * TD; c++)
        exp_q.push_back(mk(ph, u[ph] - c / TD));
    exp_q.push_back(mk(7, 0));
    exp_q.push_back(mk(0, 0));
    if (ps >= 0) begin
      h = masked(exp_q[ps]);
      for (int k = 0; k < pl; k++) exp_q.insert(ps + 1, h);
    end
    if (ab >= 0) begin
      while (exp_q.size() > ab + 1) void'(exp_q.pop_back());
      for (int c = 0; c < DR * TD; c++)
        exp_q.push_back(mk(8, DR - c / TD));
      exp_q.push_back(mk(0, 0));
    end
  endtask

  // Starts a cycle and compares every cycle against the model.
  task automatic run_trace(input int cl, input int wa,
                           input int ri, input int sp,
                           input int ps, input int pl,
                           input int ab, input int pk,
                           input string nm);
    obs_t got;
    bit   bad;
    build_exp(cl, wa, ri, sp, ps, pl, ab);
    cloth_in = W'(cl);
    wash_in  = W'(wa);
    rinse_in = W'(ri);
    spin_in  = W'(sp);
    start    = 1'b1;
    c_busy = 0; c_done = 0; c_wash = 0; c_spin = 0;
    c_done_idx = -1;
    bad = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      got = sample();
      checks++;
      if (got !== exp_q[i]) begin
        errors++;
        bad = 1'b1;
        $display("FAIL %s step %0d: got %h (ph %0d rem %0d) want %h (ph %0d rem %0d)",
                 nm, i, got, got.ph, got.rem,
                 exp_q[i], exp_q[i].ph, exp_q[i].rem);
        break;
      end
      if (got.b) c_busy++;
      if (got.d) begin c_done++; c_done_idx = i; end
      if (got.ph == 4'd2) c_wash++;
      if (got.ph == 4'd6) c_spin++;
      pause = (ps >= 0 && i >= ps && i < ps + pl);
      if (i == ab) abort = 1'b1;
      if (i == pk) begin
        start    = 1'b1;
        wash_in  = W'($urandom_range(1, 31));
        rinse_in = W'($urandom_range(0, 31));
        spin_in  = W'($urandom_range(0, 31));
        cloth_in = W'($urandom_range(1, 31));
      end
    end
    pause = 1'b0;
    abort = 1'b0;
    start = 1'b0;
    if (bad) begin
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
    end
  endtask

  task automatic test_reset();
    obs_t zero;
    zero = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sample() !== zero) begin
      errors++;
      $display("FAIL reset_hold: got %h want %h", sample(), zero);
    end
    rst_n = 1'b1;
    cloth_in = 5'd2; wash_in = 5'd3;
    rinse_in = 5'd2; spin_in = 5'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (phase !== 4'd2) begin
      errors++;
      $display("FAIL reset_prewash: phase got %0d want 2", phase);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (sample() !== zero) begin
      errors++;
      $display("FAIL reset_async: got %h want %h", sample(), zero);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    run_trace(2, 3, 2, 1, -1, 0, -1, -1, "nominal");
    checks++;
    if (c_busy !== 25) begin
      errors++;
      $display("FAIL nominal_busy: got %0d want 25", c_busy);
    end
    checks++;
    if (c_done !== 1 || c_done_idx !== 24) begin
      errors++;
      $display("FAIL nominal_done: got %0d at %0d want 1 at 24",
               c_done, c_done_idx);
    end
  endtask

  task automatic test_zero_durations();
    run_trace(2, 0, 2, 0, -1, 0, -1, -1, "zero_dur");
    checks++;
    if (c_wash !== 0 || c_spin !== 0) begin
      errors++;
      $display("FAIL zero_skip: wash %0d spin %0d want 0 0",
               c_wash, c_spin);
    end
  endtask

  task automatic test_pause();
    run_trace(2, 3, 2, 1, 6, 5, -1, -1, "pause");
    checks++;
    if (c_wash !== 11) begin
      errors++;
      $display("FAIL pause_wash_len: got %0d want 11", c_wash);
    end
    checks++;
    if (c_done_idx !== 29) begin
      errors++;
      $display("FAIL pause_done_delay: got %0d want 29",
               c_done_idx);
    end
  endtask

  task automatic test_abort();
    run_trace(2, 3, 2, 1, 15, 100, 15, -1, "abort");
    checks++;
    if (c_done !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d want 0", c_done);
    end
  endtask

  task automatic test_ignored_start();
    cloth_in = 5'd0; wash_in = 5'd3;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (phase !== 4'd0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL cloth0_start: phase %0d busy %0b want 0 0",
                 phase, busy);
      end
    end
    run_trace(2, 3, 2, 1, -1, 0, -1, 7, "start_in_wash");
    checks++;
    if (c_done_idx !== 24) begin
      errors++;
      $display("FAIL ignored_start_done: got %0d want 24",
               c_done_idx);
    end
  endtask

  task automatic test_random();
    int cl, wa, ri, sp, act, ps, pl, ab;
    for (int n = 0; n < 10; n++) begin
      cl  = $urandom_range(1, 4);
      wa  = $urandom_range(0, 3);
      ri  = $urandom_range(0, 3);
      sp  = $urandom_range(0, 3);
      act = TD * (cl + wa + ri + sp + 2 * DR);
      ps  = -1;
      pl  = 0;
      ab  = -1;
      if ($urandom_range(0, 1) == 1) begin
        ps = $urandom_range(0, act - 1);
        pl = $urandom_range(1, 4);
      end
      if ($urandom_range(0, 2) == 0)
        ab = $urandom_range(0, act + pl - 1);
      run_trace(cl, wa, ri, sp, ps, pl, ab, -1, "random");
      checks++;
      if (c_done !== ((ab < 0) ? 1 : 0)) begin
        errors++;
        $display("FAIL random_done: got %0d want %0d",
                 c_done, (ab < 0) ? 1 : 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_zero_durations();
    test_pause();
    test_abort();
    test_ignored_start();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wash_cycle_sequencer.md
Name: wash_cycle_sequencer

Overview:
- Downstream consumer of the appliance controller's washing-machine outputs: wash_out_N, rinse_out_N, spin_out_N, cloth_out_N.
- On a start request it latches those settings and runs the physical cycle as a timed state machine: fill, wash, drain, rinse, drain, spin.
- Drives the actuator outputs: water valve, drain pump, motor, door lock.
- One instance per washing machine.

Parameters:
- TICK_DIV, 10: clk cycles per time unit. Must be >= 1.
- DRAIN_UNITS, 2: fixed duration of every drain phase, in time units. Must be >= 1.
- W, 5: width of the duration and settings inputs.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle start request.
- pause  in  1  level; freezes the cycle while high.
- abort  in  1  one-cycle abort request.
- wash_in  in  W  wash duration, time units.
- rinse_in  in  W  rinse duration, time units.
- spin_in  in  W  spin duration, time units.
- cloth_in  in  W  load level; used as the fill duration, time units.
- phase  out  4  0 IDLE, 1 FILL, 2 WASH, 3 DRAIN1, 4 RINSE, 5 DRAIN2, 6 SPIN, 7 DONE, 8 ABORT_DRAIN.
- remaining  out  W  time units left in the current phase.
- valve_in  out  1  water inlet valve.
- drain_pump  out  1  drain pump.
- motor  out  2  00 off, 01 agitate, 10 spin. 11 is never driven.
- door_lock  out  1  high in every non-IDLE phase.
- busy  out  1  high when phase is not IDLE.
- done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset: rst_n low forces phase=IDLE and every output to 0, asynchronously. This applies mid-cycle too; no drain is run.
- Start acceptance: start is accepted only in IDLE with cloth_in != 0.
  - On acceptance, all four inputs are latched.
  - The next edge enters FILL with remaining=cloth.
  - start in any other phase, or with cloth_in=0, is ignored.
- Input changes after acceptance have no effect.
- Prescaler runs 0..TICK_DIV-1. A tick occurs on the cycle the count equals TICK_DIV-1.
  - The prescaler clears on every phase entry.
  - It holds while pause is high.
- Timing: each tick decrements remaining. A tick with remaining==1 leaves the phase at that edge, so a phase of N units lasts exactly N*TICK_DIV cycles.
- Order: FILL -> WASH -> DRAIN1 -> RINSE -> DRAIN2 -> SPIN -> DONE.
  - Drain phases load DRAIN_UNITS.
  - A WASH, RINSE or SPIN with zero duration is skipped: the transition goes straight to the next non-zero phase and spends no cycle in the skipped one.
- DONE lasts one cycle: done=1, door_lock=1, all actuators off. The next edge returns to IDLE.
- Actuators per phase:
  - FILL: valve_in=1.
  - WASH: motor=01.
  - DRAIN1, DRAIN2, ABORT_DRAIN: drain_pump=1.
  - RINSE: valve_in=1, motor=01.
  - SPIN: motor=10, drain_pump=1.
  - All others: actuators off.
- Pause, in any phase FILL..SPIN:
  - valve_in, drain_pump and motor are forced to 0.
  - remaining and the prescaler hold.
  - phase and door_lock are unchanged.
  - On release, timing resumes on the same count.
- Abort, in FILL..SPIN: the next edge enters ABORT_DRAIN with remaining=DRAIN_UNITS.
  - Abort has priority over pause and over a simultaneous phase-exit tick.
  - ABORT_DRAIN runs even if pause is high.
  - It exits to IDLE without a done pulse.
  - abort is ignored in IDLE, DONE and ABORT_DRAIN.
- Outputs are registered; no combinational path from any input to any output.

Decomposition:
- Shared package holds:
  - phase encoding constants;
  - motor code constants MOTOR_OFF, MOTOR_AGITATE, MOTOR_SPIN;
  - next-non-zero-phase selection function.
- One sub-module, phase_timer: prescaler plus down-counter.
  - Inputs: load, load value, hold.
  - Outputs: remaining, expire.
- The top holds the FSM and the actuator decode.

Test Plan:
All scenarios use TICK_DIV=2 and DRAIN_UNITS=2.
1. Reset: hold rst_n=0, then assert it mid-WASH -> phase=0 and all outputs 0 immediately, without waiting for a clk edge.
2. Nominal cycle: cloth=2, wash=3, rinse=2, spin=1, start pulse -> phases 1..6 last 4, 6, 4, 4, 4, 2 cycles. Then DONE for 1 cycle with done=1, then IDLE. busy high for 25 cycles.
3. Zero durations: wash=0, spin=0 -> FILL goes directly to DRAIN1; DRAIN2 goes directly to DONE; phase never reads 2 or 6.
4. Pause: high for 5 cycles mid-WASH -> motor=00, remaining frozen, door_lock=1. WASH lasts 11 cycles total; done is delayed by 5.
5. Abort: pulse in RINSE together with pause high -> ABORT_DRAIN for 4 cycles with drain_pump=1, then IDLE with door_lock=0. done never asserts.
6. Ignored starts: start with cloth=0 stays IDLE. start during WASH, or changing wash_in mid-cycle, leaves the timing identical to scenario 2.
